piso_serializer: RTL
====================

Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter: captures a WIDTH-bit word through a valid/ready load handshake, then shifts it out one bit per clk on a single serial line.
- Serves as the transmit end opposite the team's parallel/serial capture registers, i.e. the serial-out counterpart of the parallel register stage.
- Supports back-to-back words with no idle gap.
- Can optionally append one even-parity bit per frame.

Parameters:
- WIDTH, 4: data word width in bits; legal range 2..32.
- MSB_FIRST, 1: 1 = d[WIDTH-1] is sent first; 0 = d[0] is sent first.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- d  input  WIDTH  parallel word to transmit.
- load_valid  input  1  d is valid this cycle.
- load_ready  output  1  block can accept a word this cycle.
- ser_out  output  1  serial data bit.
- ser_valid  output  1  ser_out carries a frame bit this cycle.
- frame_start  output  1  high with the first bit of each frame.
- frame_done  output  1  high with the last bit of each frame.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; shift register=0; bit counter=0.
  - ser_out=0, ser_valid=0, frame_start=0, frame_done=0.
  - load_ready=1 from the first cycle after reset.
- Reset mid-frame: the frame is abandoned immediately with no further bits or frame_done. Same values as above apply.
- States:
  - IDLE: nothing being shifted.
  - SHIFT: data bits being driven.
  - PARITY: only when PARITY_EN is defined.
- Ready logic: load_ready is combinational. It is 1 in IDLE, and 1 in the cycle presenting the frame's final bit (last data bit, or the parity bit when enabled). Otherwise 0.
- Accept: occurs on a rising edge where load_valid=1 and load_ready=1.
  - d is captured into the shift register; bit counter set to 0.
  - state goes to SHIFT.
- Latency: a word accepted at edge N puts its first bit on ser_out in the cycle after edge N. Bits appear on WIDTH consecutive cycles.
- Registered outputs: ser_out, ser_valid, frame_start and frame_done all change only at clock edges.
- Bit order:
  - MSB_FIRST=1: d[WIDTH-1], d[WIDTH-2] … d[0].
  - MSB_FIRST=0: d[0], d[1] … d[WIDTH-1].
- SHIFT:
  - ser_valid=1 throughout.
  - Counter increments each cycle.
  - frame_start=1 only when counter=0.
  - frame_done=1 when counter=WIDTH-1 and parity is disabled.
- After the last data bit:
  - If an accept happens at that edge, go to SHIFT with the new word: back-to-back, no gap, frame_start asserted on the new word's first bit.
  - Otherwise go to PARITY (when enabled) or IDLE.
- IDLE outputs: ser_valid=0, ser_out=0, frame_start=0, frame_done=0.
- load_valid with load_ready=0: ignored. d is not held or queued; the source must keep load_valid asserted until it sees ready.
- Held inputs: d and load_valid changing mid-frame have no effect on the frame in flight.
- WIDTH counter: ceil(log2(WIDTH)) bits; never exceeds WIDTH-1.

Optional Feature:
- Macro: PIPO_SER_PARITY_EN.
- Defined:
  - After the last data bit, state goes to PARITY for exactly one cycle.
  - In that cycle ser_out is the XOR of all WIDTH captured bits (even parity), with ser_valid=1 and frame_done=1. frame_done is then not asserted on the last data bit.
  - Frame length is WIDTH+1 cycles.
  - Back-to-back accept happens in the PARITY cycle.
- Not defined:
  - PARITY state and logic are absent.
  - Frame length is WIDTH cycles.
  - frame_done is asserted on the last data bit.

Test Plan:
- Reset then idle, WIDTH=4 → load_ready=1, ser_valid=0, ser_out=0 for 5 cycles.
- Single word, MSB_FIRST=1: d=4'b1011 with load_valid pulsed 1 cycle → next 4 cycles ser_out=1,0,1,1; ser_valid=1,1,1,1; frame_start=1,0,0,0; frame_done=0,0,0,1; then ser_valid=0.
- LSB-first: MSB_FIRST=0, d=4'b1011 → ser_out=1,1,0,1.
- Back-to-back: load_valid held 1 with d=4'hA, then 4'h5 presented during the last-bit cycle → 8 contiguous ser_valid cycles 1,0,1,0,0,1,0,1. frame_start is high on cycles 1 and 5; load_ready is low on cycles 1–3 and 5–7.
- Reset mid-frame: rst_n=0 after the second bit of 4'hF → next cycle ser_valid=0, frame_done never asserts, load_ready=1.
- With PIPO_SER_PARITY_EN: d=4'b1011 → ser_out=1,0,1,1,1, with frame_done only on the 5th cycle. d=4'b1001 → parity bit 0.

Source files
------------

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in, serial-out transmitter.
// A WIDTH-bit word is accepted through a valid/ready handshake and driven
// out one bit per clock on ser_out, with frame_start/frame_done markers.
// Back-to-back words are sent with no idle gap.
// Optional feature: define PIPO_SER_PARITY_EN to append one even-parity bit
// after the data bits of every frame (frame length becomes WIDTH+1).
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_done
);

  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

`ifdef PIPO_SER_PARITY_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2
  } state_t;
`else
  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;
`endif

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ser_out;
  logic             r_ser_valid;
  logic             r_frame_start;
  logic             r_frame_done;
`ifdef PIPO_SER_PARITY_EN
  logic             r_parity;
`endif

  logic w_last_data;
  logic w_frame_end;
  logic w_accept;

  // Bit that goes on the line next, taken from the output end of a word.
  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  // Drop the head bit so the following bit moves to the output end.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
  endfunction

  assign w_last_data = (r_state == S_SHIFT) && (r_cnt == LAST_CNT);

`ifdef PIPO_SER_PARITY_EN
  // With parity the frame ends on the parity bit, not the last data bit.
  assign w_frame_end = (r_state == S_PARITY);
`else
  assign w_frame_end = w_last_data;
`endif

  // Ready while idle or while the final bit of the current frame is on the
  // line, so the next word can follow without a gap.
  assign load_ready = (r_state == S_IDLE) || w_frame_end;
  assign w_accept   = load_valid && load_ready;

  // Frame sequencer: load, shift, optional parity, and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_shift       <= '0;
      r_cnt         <= '0;
      r_ser_out     <= 1'b0;
      r_ser_valid   <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
`ifdef PIPO_SER_PARITY_EN
      r_parity      <= 1'b0;
`endif
    end else if (w_accept) begin
      // The first bit is presented straight from d; the register keeps the
      // remaining bits already advanced by one position.
      r_state       <= S_SHIFT;
      r_shift       <= advance(d);
      r_cnt         <= '0;
      r_ser_out     <= head_bit(d);
      r_ser_valid   <= 1'b1;
      r_frame_start <= 1'b1;
      r_frame_done  <= 1'b0;
`ifdef PIPO_SER_PARITY_EN
      r_parity      <= ^d;
`endif
    end else begin
      case (r_state)
        S_SHIFT: begin
          if (!w_last_data) begin
            r_shift       <= advance(r_shift);
            r_cnt         <= r_cnt + CNT_W'(1);
            r_ser_out     <= head_bit(r_shift);
            r_ser_valid   <= 1'b1;
            r_frame_start <= 1'b0;
`ifdef PIPO_SER_PARITY_EN
            r_frame_done  <= 1'b0;
`else
            r_frame_done  <= ((r_cnt + CNT_W'(1)) == LAST_CNT);
`endif
          end else begin
            r_cnt         <= '0;
`ifdef PIPO_SER_PARITY_EN
            // One extra cycle carrying the even-parity bit of the word.
            r_state       <= S_PARITY;
            r_ser_out     <= r_parity;
            r_ser_valid   <= 1'b1;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b1;
`else
            r_state       <= S_IDLE;
            r_ser_out     <= 1'b0;
            r_ser_valid   <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
`endif
          end
        end
`ifdef PIPO_SER_PARITY_EN
        S_PARITY: begin
          r_state       <= S_IDLE;
          r_ser_out     <= 1'b0;
          r_ser_valid   <= 1'b0;
          r_frame_start <= 1'b0;
          r_frame_done  <= 1'b0;
        end
`endif
        default: begin
          r_state       <= S_IDLE;
          r_ser_out     <= 1'b0;
          r_ser_valid   <= 1'b0;
          r_frame_start <= 1'b0;
          r_frame_done  <= 1'b0;
        end
      endcase
    end
  end

  assign ser_out     = r_ser_out;
  assign ser_valid   = r_ser_valid;
  assign frame_start = r_frame_start;
  assign frame_done  = r_frame_done;

endmodule
